// File: rtl/avst_pkt_arbiter.sv
// Two-source, packet-atomic, round-robin arbiter for Avalon-ST streams.
// Optional per-source EOP counters are enabled by defining AVST_ARB_PKT_COUNT_EN.
module avst_pkt_arbiter #(
  parameter int DATA_W = 64,
  parameter int CNT_W  = 32
) (
  input  logic              clock_clk,
  input  logic              clock_rst_n,
  input  logic [DATA_W-1:0] asi0_data,
  input  logic              asi0_valid,
  output logic              asi0_ready,
  input  logic              asi0_startofpacket,
  input  logic              asi0_endofpacket,
  input  logic              asi0_error,
  input  logic [DATA_W-1:0] asi1_data,
  input  logic              asi1_valid,
  output logic              asi1_ready,
  input  logic              asi1_startofpacket,
  input  logic              asi1_endofpacket,
  input  logic              asi1_error,
  output logic [DATA_W-1:0] aso_data,
  output logic              aso_valid,
  input  logic              aso_ready,
  output logic              aso_startofpacket,
  output logic              aso_endofpacket,
  output logic              aso_error,
  output logic [1:0]        arb_grant
`ifdef AVST_ARB_PKT_COUNT_EN
  ,
  output logic [CNT_W-1:0]  pkt_count0,
  output logic [CNT_W-1:0]  pkt_count1
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_e;

  state_e     state_q;
  logic       last_grant_q;
  logic [1:0] grant_q;
  logic       eop_xfer0, eop_xfer1;

  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("CNT_W must be at least 1");
  end

  assign eop_xfer0 = (state_q == OWN0) && asi0_valid && aso_ready && asi0_endofpacket;
  assign eop_xfer1 = (state_q == OWN1) && asi1_valid && aso_ready && asi1_endofpacket;
  assign arb_grant = grant_q;

  // Zero-latency pass-through from the current owner; everything is quiet when idle.
  always_comb begin
    aso_data          = '0;
    aso_valid         = 1'b0;
    aso_startofpacket = 1'b0;
    aso_endofpacket   = 1'b0;
    aso_error         = 1'b0;
    asi0_ready        = 1'b0;
    asi1_ready        = 1'b0;
    case (state_q)
      OWN0: begin
        aso_data          = asi0_data;
        aso_valid         = asi0_valid;
        aso_startofpacket = asi0_startofpacket;
        aso_endofpacket   = asi0_endofpacket;
        aso_error         = asi0_error;
        asi0_ready        = aso_ready;
      end
      OWN1: begin
        aso_data          = asi1_data;
        aso_valid         = asi1_valid;
        aso_startofpacket = asi1_startofpacket;
        aso_endofpacket   = asi1_endofpacket;
        aso_error         = asi1_error;
        asi1_ready        = aso_ready;
      end
      default: ;
    endcase
  end

  // Grant is registered alongside the state, which costs one bubble between packets.
  always_ff @(posedge clock_clk) begin
    if (!clock_rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      grant_q      <= 2'b00;
    end else begin
      case (state_q)
        IDLE: begin
          // On a tie the source that did not finish last wins.
          if (asi0_valid && (!asi1_valid || last_grant_q)) begin
            state_q <= OWN0;
            grant_q <= 2'b01;
          end else if (asi1_valid) begin
            state_q <= OWN1;
            grant_q <= 2'b10;
          end
        end
        OWN0: begin
          if (eop_xfer0) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b0;
            grant_q      <= 2'b00;
          end
        end
        OWN1: begin
          if (eop_xfer1) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            grant_q      <= 2'b00;
          end
        end
        default: begin
          state_q <= IDLE;
          grant_q <= 2'b00;
        end
      endcase
    end
  end

`ifdef AVST_ARB_PKT_COUNT_EN
  logic [CNT_W-1:0] cnt0_q, cnt1_q;

  // Free-running wrap on overflow is intended.
  always_ff @(posedge clock_clk) begin
    if (!clock_rst_n) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      if (eop_xfer0) cnt0_q <= cnt0_q + 1'b1;
      if (eop_xfer1) cnt1_q <= cnt1_q + 1'b1;
    end
  end

  assign pkt_count0 = cnt0_q;
  assign pkt_count1 = cnt1_q;
`endif

endmodule

// File: tb/tb_avst_pkt_arbiter.sv
// Directed bench for avst_pkt_arbiter: per-source beat scoreboards plus cycle-exact grant checks.
module tb_avst_pkt_arbiter;
  typedef struct packed {
    logic [63:0] data;
    logic        sop;
    logic        eop;
    logic        err;
  } beat_t;

  logic        clock_clk = 1'b0;
  logic        clock_rst_n = 1'b0;
  logic [63:0] asi0_data = '0, asi1_data = '0;
  logic        asi0_valid = 1'b0, asi1_valid = 1'b0;
  logic        asi0_startofpacket = 1'b0, asi1_startofpacket = 1'b0;
  logic        asi0_endofpacket = 1'b0, asi1_endofpacket = 1'b0;
  logic        asi0_error = 1'b0, asi1_error = 1'b0;
  logic        asi0_ready, asi1_ready;
  logic [63:0] aso_data;
  logic        aso_valid, aso_startofpacket, aso_endofpacket, aso_error;
  logic        aso_ready = 1'b1;
  logic [1:0]  arb_grant;
`ifdef AVST_ARB_PKT_COUNT_EN
  logic [31:0] pkt_count0, pkt_count1;
`endif

  int    n_vec = 0, n_err = 0;
  beat_t q0[$], q1[$], e0[$], e1[$];
  logic  en0 = 1'b1, en1 = 1'b1;

  always #5 clock_clk = ~clock_clk;

  avst_pkt_arbiter #(.DATA_W(64), .CNT_W(32)) dut (
    .clock_clk(clock_clk), .clock_rst_n(clock_rst_n),
    .asi0_data(asi0_data), .asi0_valid(asi0_valid), .asi0_ready(asi0_ready),
    .asi0_startofpacket(asi0_startofpacket), .asi0_endofpacket(asi0_endofpacket),
    .asi0_error(asi0_error),
    .asi1_data(asi1_data), .asi1_valid(asi1_valid), .asi1_ready(asi1_ready),
    .asi1_startofpacket(asi1_startofpacket), .asi1_endofpacket(asi1_endofpacket),
    .asi1_error(asi1_error),
    .aso_data(aso_data), .aso_valid(aso_valid), .aso_ready(aso_ready),
    .aso_startofpacket(aso_startofpacket), .aso_endofpacket(aso_endofpacket),
    .aso_error(aso_error), .arb_grant(arb_grant)
`ifdef AVST_ARB_PKT_COUNT_EN
    , .pkt_count0(pkt_count0), .pkt_count1(pkt_count1)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic send(input int src, input int nbeats);
    beat_t b;
    for (int i = 0; i < nbeats; i++) begin
      b.data = {$urandom, $urandom};
      b.sop  = (i == 0);
      b.eop  = (i == nbeats - 1);
      b.err  = 1'($urandom_range(0, 1));
      if (src == 0) begin q0.push_back(b); e0.push_back(b); end
      else          begin q1.push_back(b); e1.push_back(b); end
    end
  endtask

  task automatic wait_idle();
    logic done;
    done = 1'b0;
    for (int i = 0; i < 300 && !done; i++) begin
      @(posedge clock_clk); #1;
      done = (q0.size() == 0) && (q1.size() == 0) && (arb_grant == 2'b00);
    end
    chk("idle_reached", done, 1'b1);
  endtask

  // Source 0 model: presents the queue head, retires it after an accepted beat.
  initial begin : src0
    logic f;
    f = 1'b0;
    forever begin
      @(posedge clock_clk); #3;
      if (f && q0.size() > 0) void'(q0.pop_front());
      if (en0 && q0.size() > 0) begin
        asi0_valid = 1'b1; asi0_data = q0[0].data;
        asi0_startofpacket = q0[0].sop; asi0_endofpacket = q0[0].eop; asi0_error = q0[0].err;
      end else begin
        asi0_valid = 1'b0; asi0_data = '0;
        asi0_startofpacket = 1'b0; asi0_endofpacket = 1'b0; asi0_error = 1'b0;
      end
      @(negedge clock_clk);
      f = asi0_valid & asi0_ready & clock_rst_n;
    end
  end

  initial begin : src1
    logic f;
    f = 1'b0;
    forever begin
      @(posedge clock_clk); #3;
      if (f && q1.size() > 0) void'(q1.pop_front());
      if (en1 && q1.size() > 0) begin
        asi1_valid = 1'b1; asi1_data = q1[0].data;
        asi1_startofpacket = q1[0].sop; asi1_endofpacket = q1[0].eop; asi1_error = q1[0].err;
      end else begin
        asi1_valid = 1'b0; asi1_data = '0;
        asi1_startofpacket = 1'b0; asi1_endofpacket = 1'b0; asi1_error = 1'b0;
      end
      @(negedge clock_clk);
      f = asi1_valid & asi1_ready & clock_rst_n;
    end
  end

  // Every accepted output beat is matched against the owning source's expected queue.
  initial begin : monitor
    beat_t b;
    int    avail;
    forever begin
      @(negedge clock_clk);
      if (clock_rst_n && aso_valid && aso_ready) begin
        chk("beat_grant_onehot", (arb_grant == 2'b01) || (arb_grant == 2'b10), 1'b1);
        avail = (arb_grant == 2'b10) ? e1.size() : e0.size();
        chk("sb_has_beat", avail != 0, 1'b1);
        if (avail != 0) begin
          b = (arb_grant == 2'b10) ? e1.pop_front() : e0.pop_front();
          chk("beat_data", aso_data, b.data);
          chk("beat_sop", aso_startofpacket, b.sop);
          chk("beat_eop", aso_endofpacket, b.eop);
          chk("beat_err", aso_error, b.err);
        end
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : main
    logic [1:0] gseq [13];
    gseq = '{2'b00, 2'b01, 2'b01, 2'b01, 2'b00, 2'b10, 2'b10, 2'b10,
             2'b00, 2'b01, 2'b01, 2'b01, 2'b00};

    // Reset held with both sources valid, three packets pending for the tie test.
    send(0, 3); send(1, 3); send(0, 3);
    for (int k = 0; k < 2; k++) begin
      @(posedge clock_clk); @(negedge clock_clk);
      chk("rst_aso_valid", aso_valid, 1'b0);
      chk("rst_ready0", asi0_ready, 1'b0);
      chk("rst_ready1", asi1_ready, 1'b0);
      chk("rst_grant", arb_grant, 2'b00);
    end
    @(posedge clock_clk); #1;
    clock_rst_n = 1'b1;

    // Tie from reset: src0, bubble, src1, bubble, src0.
    for (int k = 0; k < 13; k++) begin
      @(negedge clock_clk);
      chk("tie_grant_seq", arb_grant, gseq[k]);
    end
    wait_idle();

    // Atomicity: src1 arrives mid-packet and must wait for src0 EOP.
    en1 = 1'b0;
    send(0, 4); send(1, 2);
    @(posedge clock_clk); #1;
    @(posedge clock_clk); #1;
    en1 = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock_clk);
      chk("atom_src1_valid", asi1_valid, 1'b1);
      chk("atom_src1_held", asi1_ready, 1'b0);
      chk("atom_grant0", arb_grant, 2'b01);
    end
    @(negedge clock_clk);
    chk("atom_bubble", arb_grant, 2'b00);
    chk("atom_bubble_ready1", asi1_ready, 1'b0);
    @(negedge clock_clk);
    chk("atom_grant1", arb_grant, 2'b10);
    chk("atom_ready1", asi1_ready, 1'b1);
    wait_idle();

    // Backpressure: five stalled cycles mid-packet, data must hold.
    send(1, 6);
    for (int k = 0; k < 3; k++) begin @(posedge clock_clk); #1; end
    aso_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clock_clk);
      chk("bp_data_held", aso_data, e1[0].data);
      chk("bp_valid", aso_valid, 1'b1);
      chk("bp_ready1", asi1_ready, 1'b0);
    end
    @(posedge clock_clk); #1;
    aso_ready = 1'b1;
    wait_idle();

    // Ten single-beat packets: one bubble per packet.
    for (int k = 0; k < 10; k++) send(0, 1);
    for (int k = 0; k < 20; k++) begin
      @(negedge clock_clk);
      chk("sbeat_grant", arb_grant, (k % 2 == 0) ? 2'b00 : 2'b01);
    end
    wait_idle();
`ifdef AVST_ARB_PKT_COUNT_EN
    chk("pkt_count0", pkt_count0, 32'd13);
    chk("pkt_count1", pkt_count1, 32'd3);
`endif

    // Mid-packet reset during beat 2 of src1; afterwards src0 must win a tie.
    send(1, 4);
    @(posedge clock_clk); #1;
    @(posedge clock_clk); #1;
    clock_rst_n = 1'b0;
    @(posedge clock_clk); #1;
    clock_rst_n = 1'b1;
    q1.delete(); e1.delete();
    send(0, 2); send(1, 2);
    @(negedge clock_clk);
    chk("mrst_idle_grant", arb_grant, 2'b00);
    chk("mrst_idle_valid", aso_valid, 1'b0);
    @(negedge clock_clk);
    chk("mrst_tie_src0", arb_grant, 2'b01);
    wait_idle();
`ifdef AVST_ARB_PKT_COUNT_EN
    chk("mrst_count0", pkt_count0, 32'd1);
    chk("mrst_count1", pkt_count1, 32'd1);
`endif

    chk("sb_drained0", e0.size(), 0);
    chk("sb_drained1", e1.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
